// File: rtl/prog_ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_ram_loader_if
// Brief    : Byte-stream load, session control and fetch-read bundle.
// Revision : 1.0
// ============================================================================
interface prog_ram_loader_if #(
   parameter int WIDTH  = 32,
   parameter int LENGTH = 256
);
   localparam int AW = $clog2(LENGTH);

   logic             start;
   logic             finish;
   logic             in_valid;
   logic [7:0]       in_byte;
   logic             in_ready;
   logic [WIDTH-1:0] r_addr;
   logic [WIDTH-1:0] rd;
   logic             busy;
   logic             done;
   logic [AW:0]      word_count;

   modport master (
      output start, finish, in_valid, in_byte, r_addr,
      input  in_ready, rd, busy, done, word_count
   );

   modport slave (
      input  start, finish, in_valid, in_byte, r_addr,
      output in_ready, rd, busy, done, word_count
   );
endinterface
`default_nettype wire

// File: rtl/prog_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_ram_loader
// Brief    : Packs a byte stream into little-endian words in a RAM that the
//            core fetches from through a registered read port.
// Revision : 1.0
// ============================================================================
module prog_ram_loader #(
   parameter int WIDTH  = 32,
   parameter int LENGTH = 256
) (
   input  wire logic          clk,
   input  wire logic          reset,
   prog_ram_loader_if.slave   bus
);
   localparam int            AW     = $clog2(LENGTH);
   localparam logic [AW-1:0] C_LAST = AW'(LENGTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [1:0]       r_byte_cnt;
   logic [AW-1:0]    r_word_addr;
   logic [AW:0]      r_word_count;
   logic [23:0]      r_asm;
   logic [WIDTH-1:0] r_rd;
   logic [WIDTH-1:0] r_mem [LENGTH];

   logic             w_in_ready;
   logic             w_busy;
   logic             w_done;
   logic             w_accept;
   logic             w_we;
   logic [1:0]       w_cnt_after;
   logic [WIDTH-1:0] w_wdata;
   logic             w_restart;
   logic             w_unused;

   assign w_restart = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
   assign w_unused  = &{1'b0, bus.r_addr};

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_accept    = 1'b0;
      w_we        = 1'b0;
      w_cnt_after = r_byte_cnt;
      w_wdata     = WIDTH'({bus.in_byte, r_asm});
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_next = S_LOAD;
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            w_busy     = 1'b1;
            w_accept   = bus.in_valid;
            if (w_accept) w_cnt_after = r_byte_cnt + 2'd1;
            w_we       = w_accept && (r_byte_cnt == 2'd3);
            // A full RAM ends the session regardless of finish.
            if (w_we && (r_word_addr == C_LAST))
               w_next = S_DONE;
            else if (bus.finish)
               w_next = (w_cnt_after == 2'd0) ? S_DONE : S_FLUSH;
         end
         S_FLUSH: begin
            w_busy  = 1'b1;
            w_we    = 1'b1;
            w_wdata = WIDTH'({8'h00, r_asm});
            w_next  = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            if (bus.start) w_next = S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_byte_cnt   <= 2'd0;
         r_word_addr  <= '0;
         r_word_count <= '0;
         r_asm        <= '0;
      end else begin
         r_state <= w_next;
         if (w_restart) begin
            r_byte_cnt   <= 2'd0;
            r_word_addr  <= '0;
            r_word_count <= '0;
            r_asm        <= '0;
         end
         if (w_accept) begin
            r_byte_cnt <= w_cnt_after;
            case (r_byte_cnt)
               2'd0: r_asm[7:0]   <= bus.in_byte;
               2'd1: r_asm[15:8]  <= bus.in_byte;
               2'd2: r_asm[23:16] <= bus.in_byte;
               default: begin
                  r_asm        <= '0;
                  r_word_addr  <= r_word_addr + AW'(1);
                  r_word_count <= r_word_count + (AW+1)'(1);
               end
            endcase
         end
         if (r_state == S_FLUSH) begin
            r_word_count <= r_word_count + (AW+1)'(1);
            r_byte_cnt   <= 2'd0;
            r_asm        <= '0;
         end
      end
   end

   // RAM array is never reset; a reset cycle only suppresses the write.
   always_ff @(posedge clk) begin
      if (w_we && !reset) r_mem[r_word_addr] <= w_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) r_rd <= '0;
      else       r_rd <= r_mem[bus.r_addr[AW+1:2]];
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.busy       = w_busy;
   assign bus.done       = w_done;
   assign bus.word_count = r_word_count;
   assign bus.rd         = r_rd;
endmodule
`default_nettype wire

// File: tb/tb_prog_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_ram_loader
// Brief    : Scoreboard bench driving a 256-word and a 4-word loader in step.
// Revision : 1.0
// ============================================================================
module tb_prog_ram_loader;
   typedef struct {
      bit          care;
      logic [31:0] val;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic        finish;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic [31:0] r_addr;
   logic        rd_req;
   logic        rd_req_d;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  sb [$];
   exp_t        q_m [$];
   exp_t        q_s [$];
   logic [31:0] mm [256];
   bit          mv [256];
   logic [31:0] ms [4];
   bit          sv [4];

   prog_ram_loader_if #(.WIDTH(32), .LENGTH(256)) bus_m ();
   prog_ram_loader_if #(.WIDTH(32), .LENGTH(4))   bus_s ();

   assign bus_m.start = start;   assign bus_s.start = start;
   assign bus_m.finish = finish; assign bus_s.finish = finish;
   assign bus_m.in_valid = in_valid; assign bus_s.in_valid = in_valid;
   assign bus_m.in_byte = in_byte;   assign bus_s.in_byte = in_byte;
   assign bus_m.r_addr = r_addr;     assign bus_s.r_addr = r_addr;

   prog_ram_loader #(.WIDTH(32), .LENGTH(256)) u_dut (
      .clk(clk), .reset(reset), .bus(bus_m.slave));
   prog_ram_loader #(.WIDTH(32), .LENGTH(4)) u_small (
      .clk(clk), .reset(reset), .bus(bus_s.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every read issued one cycle earlier is compared against the queue.
   always @(posedge clk) rd_req_d <= rd_req;

   always @(negedge clk) begin
      exp_t e;
      if (rd_req_d) begin
         if (q_m.size() == 0 || q_s.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow: got empty queue expected entry");
         end else begin
            e = q_m.pop_front();
            if (e.care) chk("rd_main", bus_m.rd, e.val);
            e = q_s.pop_front();
            if (e.care) chk("rd_small", bus_s.rd, e.val);
         end
      end
   end

   function automatic logic [31:0] mk_word(int w, int acc);
      logic [31:0] v = '0;
      for (int k = 0; k < 4; k++)
         if (4*w + k < acc) v[8*k +: 8] = sb[4*w + k];
      return v;
   endfunction

   task automatic do_read(input logic [31:0] a);
      exp_t e;
      @(negedge clk);
      r_addr = a;
      rd_req = 1'b1;
      e.care = mv[a[9:2]]; e.val = mm[a[9:2]]; q_m.push_back(e);
      e.care = sv[a[3:2]]; e.val = ms[a[3:2]]; q_s.push_back(e);
   endtask

   task automatic read_end();
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   // mode 0: finish after last byte, 1: finish with last byte, 3: reset after last byte
   task automatic run_session(input int mode, input bit gaps);
      int n     = sb.size();
      int acc_s = (n < 16) ? n : 16;
      int nw_m, nw_s;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("load_busy_m", {31'd0, bus_m.busy}, 32'd1);
      chk("load_rdy_m", {31'd0, bus_m.in_ready}, 32'd1);
      chk("load_busy_s", {31'd0, bus_s.busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; finish = 1'b0; @(negedge clk);
         end
         in_valid = 1'b1;
         in_byte  = sb[i];
         finish   = (mode == 1) && (i == n - 1);
         @(negedge clk);
         if (i == 15) begin
            chk("full_done_s", {31'd0, bus_s.done}, 32'd1);
            chk("full_rdy_s", {31'd0, bus_s.in_ready}, 32'd0);
         end
      end
      in_valid = 1'b0;
      finish   = 1'b0;
      if (mode == 3) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         chk("rst_busy_m", {31'd0, bus_m.busy}, 32'd0);
         chk("rst_done_m", {31'd0, bus_m.done}, 32'd0);
         chk("rst_wc_m", 32'(bus_m.word_count), 32'd0);
         chk("rst_rd_m", bus_m.rd, 32'd0);
         chk("rst_wc_s", 32'(bus_s.word_count), 32'd0);
         nw_m = n / 4;
         nw_s = acc_s / 4;
      end else begin
         if (mode == 0) begin
            finish = 1'b1; @(negedge clk); finish = 1'b0;
         end
         if (n % 4 == 0) begin
            chk("fin_done_m", {31'd0, bus_m.done}, 32'd1);
            chk("fin_busy_m", {31'd0, bus_m.busy}, 32'd0);
         end else begin
            chk("flush_done_m", {31'd0, bus_m.done}, 32'd0);
            chk("flush_busy_m", {31'd0, bus_m.busy}, 32'd1);
            chk("flush_rdy_m", {31'd0, bus_m.in_ready}, 32'd0);
         end
         @(negedge clk);
         nw_m = (n + 3) / 4;
         nw_s = (acc_s + 3) / 4;
         chk("end_done_m", {31'd0, bus_m.done}, 32'd1);
         chk("end_busy_m", {31'd0, bus_m.busy}, 32'd0);
         chk("end_rdy_m", {31'd0, bus_m.in_ready}, 32'd0);
         chk("end_wc_m", 32'(bus_m.word_count), 32'(nw_m));
         chk("end_done_s", {31'd0, bus_s.done}, 32'd1);
         chk("end_wc_s", 32'(bus_s.word_count), 32'(nw_s));
      end
      for (int w = 0; w < nw_m; w++) begin mm[w] = mk_word(w, n);     mv[w] = 1'b1; end
      for (int w = 0; w < nw_s; w++) begin ms[w] = mk_word(w, acc_s); sv[w] = 1'b1; end
   endtask

   task automatic collision_test();
      logic [7:0] bytes [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
      @(negedge clk); start = 1'b1; r_addr = 32'h0;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_byte = bytes[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("rdw_old", bus_m.rd, 32'h12345678);
      @(negedge clk);
      chk("rdw_new", bus_m.rd, 32'hCAFEF00D);
      finish = 1'b1; @(negedge clk); finish = 1'b0;
      chk("rdw_wc_m", 32'(bus_m.word_count), 32'd1);
      mm[0] = 32'hCAFEF00D; ms[0] = 32'hCAFEF00D;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, mode;
      reset = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      in_byte = '0; r_addr = '0; rd_req = 1'b0;
      for (int i = 0; i < 256; i++) mv[i] = 1'b0;
      for (int i = 0; i < 4; i++)   sv[i] = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rd_m", bus_m.rd, 32'd0);
      chk("reset_busy_m", {31'd0, bus_m.busy}, 32'd0);
      chk("reset_done_m", {31'd0, bus_m.done}, 32'd0);
      chk("reset_rdy_m", {31'd0, bus_m.in_ready}, 32'd0);
      chk("reset_wc_m", 32'(bus_m.word_count), 32'd0);
      chk("reset_done_s", {31'd0, bus_s.done}, 32'd0);
      reset = 1'b0;

      sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      run_session(0, 1'b0);
      do_read(32'h4); do_read(32'h0); read_end();

      sb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      run_session(0, 1'b0);
      do_read(32'h4); read_end();

      sb.delete();
      for (int i = 0; i < 17; i++) sb.push_back(8'(i));
      run_session(0, 1'b0);
      do_read(32'hC); do_read(32'h10); read_end();

      sb = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_session(1, 1'b0);
      do_read(32'h0); read_end();

      sb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      run_session(3, 1'b0);
      do_read(32'h0); read_end();

      sb = '{8'h78, 8'h56, 8'h34, 8'h12};
      run_session(0, 1'b0);
      collision_test();
      do_read(32'h403); do_read(32'h0); read_end();

      for (int s = 0; s < 14; s++) begin
         n    = $urandom_range(0, 40);
         mode = (n == 0) ? 0 : ((s % 5 == 4) ? 3 : $urandom_range(0, 1));
         sb.delete();
         for (int i = 0; i < n; i++) sb.push_back(8'($urandom));
         run_session(mode, 1'($urandom));
         for (int r = 0; r < 5; r++)
            do_read(($urandom & 32'hFFFF_FC03) | (32'($urandom_range(0, 11)) << 2));
         read_end();
      end

      chk("sb_drain_m", 32'(q_m.size()), 32'd0);
      chk("sb_drain_s", 32'(q_s.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
